// File: rtl/inst_cache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the core fetch port and a
// multi-cycle request/ack instruction bus; misses stall the pipeline until the refill lands.
module inst_cache_direct #(
  parameter int INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rom_chip_enable,
  input  logic [ADDR_WIDTH-1:0] rom_address_input,
  output logic [DATA_WIDTH-1:0] rom_data_output,
  output logic                  stop_all_req_from_if,
  input  logic                  invalidate,
  output logic                  bus_request,
  output logic [ADDR_WIDTH-1:0] bus_address,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_data
);

  localparam int LINE_COUNT = 2 ** INDEX_WIDTH;
  localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  logic [0:0]            r_state;
  logic [LINE_COUNT-1:0] r_valid;
  logic                  r_drop;
  logic                  r_bus_request;
  logic [ADDR_WIDTH-1:0] r_bus_address;
  logic [TAG_WIDTH-1:0]  r_tag_mem  [LINE_COUNT];
  logic [DATA_WIDTH-1:0] r_data_mem [LINE_COUNT];

  logic [INDEX_WIDTH-1:0] w_index;
  logic [INDEX_WIDTH-1:0] w_fill_index;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic [TAG_WIDTH-1:0]   w_fill_tag;
  logic                   w_hit;
  logic                   w_miss;
  logic                   w_fill_done;
  logic                   w_unused_offset;

  assign w_index      = rom_address_input[INDEX_WIDTH+1:2];
  assign w_tag        = rom_address_input[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign w_fill_index = r_bus_address[INDEX_WIDTH+1:2];
  assign w_fill_tag   = r_bus_address[ADDR_WIDTH-1:INDEX_WIDTH+2];

  // Byte offset within the word never selects anything.
  assign w_unused_offset = ^rom_address_input[1:0];

  assign w_hit       = rom_chip_enable & r_valid[w_index] & (r_tag_mem[w_index] == w_tag);
  assign w_miss      = (r_state == ST_IDLE) & rom_chip_enable & ~w_hit;
  assign w_fill_done = (r_state == ST_FILL) & bus_ack;

  assign rom_data_output = w_hit ? r_data_mem[w_index] : '0;

  // Stall is gated by reset so a held reset never freezes the pipeline.
  assign stop_all_req_from_if = reset & ((r_state == ST_FILL) | (rom_chip_enable & ~w_hit));

  assign bus_request = r_bus_request;
  assign bus_address = r_bus_address;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_valid       <= '0;
      r_drop        <= 1'b0;
      r_bus_request <= 1'b0;
      r_bus_address <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_miss) begin
          r_state       <= ST_FILL;
          r_bus_request <= 1'b1;
          r_bus_address <= {rom_address_input[ADDR_WIDTH-1:2], 2'b00};
        end
      end else if (bus_ack) begin
        r_state       <= ST_IDLE;
        r_bus_request <= 1'b0;
      end

      // Invalidate wins over a completing fill, so an ack in the same cycle stays invalid.
      if (invalidate) begin
        r_valid <= '0;
      end else if (w_fill_done && !r_drop) begin
        r_valid[w_fill_index] <= 1'b1;
      end

      if (w_fill_done) begin
        r_drop <= 1'b0;
      end else if (invalidate && (r_state == ST_FILL)) begin
        r_drop <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their
  // contents are ever observed, which keeps the arrays mappable to plain RAM.
  always_ff @(posedge clock) begin
    if (w_fill_done) begin
      r_tag_mem[w_fill_index]  <= w_fill_tag;
      r_data_mem[w_fill_index] <= bus_data;
    end
  end

endmodule

// File: tb/tb_inst_cache_direct.sv
// Self-checking bench for inst_cache_direct: directed scenarios followed by random fetches,
// compared against an address-keyed model of what the cache currently holds.
module tb_inst_cache_direct;

  logic        clock = 1'b0;
  logic        reset;
  logic        rom_chip_enable;
  logic [31:0] rom_address_input;
  logic [31:0] rom_data_output;
  logic        stop_all_req_from_if;
  logic        invalidate;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_ack;
  logic [31:0] bus_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: backing memory and the set of word addresses currently cached.
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] cached [logic [31:0]];

  inst_cache_direct dut (
    .clock                (clock),
    .reset                (reset),
    .rom_chip_enable      (rom_chip_enable),
    .rom_address_input    (rom_address_input),
    .rom_data_output      (rom_data_output),
    .stop_all_req_from_if (stop_all_req_from_if),
    .invalidate           (invalidate),
    .bus_request          (bus_request),
    .bus_address          (bus_address),
    .bus_ack              (bus_ack),
    .bus_data             (bus_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] w);
    if (!mem.exists(w)) mem[w] = $urandom | 32'h1;
    return mem[w];
  endfunction

  function automatic bit model_hit(input logic [31:0] w);
    return cached.exists(w);
  endfunction

  // A line holds one word per index, so a fill evicts anything sharing address bits [5:2].
  function automatic void model_fill(input logic [31:0] w, input logic [31:0] d);
    logic [31:0] victims[$];
    foreach (cached[k]) if (k[5:2] == w[5:2]) victims.push_back(k);
    foreach (victims[i]) cached.delete(victims[i]);
    cached[w] = d;
  endfunction

  // Starts and ends at one time unit after a rising edge. inv_mode: 0 none,
  // 1 invalidate on the ack cycle, 2 invalidate the cycle before the ack.
  task automatic fetch(input logic [31:0] a, input int dly, input int inv_mode);
    logic [31:0] w;
    logic [31:0] d;
    bit          drop;
    w    = {a[31:2], 2'b00};
    drop = 0;
    rom_chip_enable   = 1'b1;
    rom_address_input = a;
    @(negedge clock);
    if (model_hit(w)) begin
      check("hit_stall", stop_all_req_from_if, 0);
      check("hit_data", rom_data_output, cached[w]);
      check("hit_noreq", bus_request, 0);
      rom_chip_enable = 1'b0;
      @(posedge clock); #1;
      return;
    end
    check("miss_stall", stop_all_req_from_if, 1);
    check("miss_data", rom_data_output, 0);
    @(posedge clock); #1;
    for (int i = 0; i < dly; i++) begin
      if (inv_mode == 2 && i == dly - 1) invalidate = 1'b1;
      @(negedge clock);
      check("fill_req", bus_request, 1);
      check("fill_addr", bus_address, w);
      check("fill_stall", stop_all_req_from_if, 1);
      @(posedge clock); #1;
      if (invalidate) begin
        cached.delete();
        drop = 1;
        invalidate = 1'b0;
      end
    end
    d        = mem_word(w);
    bus_ack  = 1'b1;
    bus_data = d;
    if (inv_mode == 1) invalidate = 1'b1;
    @(negedge clock);
    check("ack_req", bus_request, 1);
    check("ack_addr", bus_address, w);
    check("ack_stall", stop_all_req_from_if, 1);
    @(posedge clock); #1;
    bus_ack  = 1'b0;
    bus_data = $urandom;
    if (invalidate) begin
      cached.delete();
      drop = 1;
      invalidate = 1'b0;
    end
    if (!drop) model_fill(w, d);
    @(negedge clock);
    check("post_req", bus_request, 0);
    check("post_stall", stop_all_req_from_if, model_hit(w) ? 32'd0 : 32'd1);
    check("post_data", rom_data_output, model_hit(w) ? d : 32'd0);
    rom_chip_enable = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic idle_stray();
    rom_chip_enable   = 1'b0;
    rom_address_input = $urandom;
    bus_ack           = 1'b1;
    bus_data          = $urandom;
    @(negedge clock);
    check("idle_data", rom_data_output, 0);
    check("idle_stall", stop_all_req_from_if, 0);
    check("idle_req", bus_request, 0);
    @(posedge clock); #1;
    bus_ack = 1'b0;
  endtask

  task automatic invalidate_idle();
    rom_chip_enable = 1'b0;
    invalidate      = 1'b1;
    @(posedge clock); #1;
    invalidate = 1'b0;
    cached.delete();
  endtask

  task automatic reset_mid_fill(input logic [31:0] a);
    rom_chip_enable   = 1'b1;
    rom_address_input = a;
    @(negedge clock);
    check("rst_pre_stall", stop_all_req_from_if, 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_pre_req", bus_request, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_req", bus_request, 0);
    check("rst_addr", bus_address, 0);
    check("rst_stall", stop_all_req_from_if, 0);
    check("rst_data", rom_data_output, 0);
    @(posedge clock); #1;
    check("rst_held_stall", stop_all_req_from_if, 0);
    check("rst_held_req", bus_request, 0);
    @(negedge clock);
    reset           = 1'b1;
    rom_chip_enable = 1'b0;
    cached.delete();
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] tags [4];
    logic [31:0] a;
    int          sel;
    int          inv;
    tags = '{32'h0, 32'h1, 32'h2, 32'h3FF_FFFF};

    reset             = 1'b0;
    rom_chip_enable   = 1'b1;
    rom_address_input = 32'h0;
    invalidate        = 1'b0;
    bus_ack           = 1'b0;
    bus_data          = 32'h0;
    mem[32'h0]        = 32'h3401_1100;
    mem[32'h40]       = 32'h3C01_0000;

    #1;
    check("reset_req", bus_request, 0);
    check("reset_addr", bus_address, 0);
    check("reset_stall", stop_all_req_from_if, 0);
    check("reset_data", rom_data_output, 0);
    @(negedge clock);
    reset           = 1'b1;
    rom_chip_enable = 1'b0;
    @(posedge clock); #1;

    fetch(32'h0, 3, 0);           // cold miss
    fetch(32'h0, 0, 0);           // hit
    fetch(32'h40, 1, 0);          // conflict on index 0
    fetch(32'h0, 2, 0);           // evicted, misses again
    fetch(32'h40, 0, 1);          // invalidate with ack
    fetch(32'h40, 1, 0);          // still invalid, refills
    fetch(32'h42, 0, 0);          // byte offset ignored
    fetch(32'h44, 2, 2);          // invalidate mid-fill
    fetch(32'h44, 0, 0);
    idle_stray();
    fetch(32'h44, 0, 0);          // stray ack changed nothing
    invalidate_idle();
    fetch(32'h44, 1, 0);
    reset_mid_fill(32'h88);
    fetch(32'h0, 1, 0);           // valid bits cleared by reset

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        idle_stray();
      end else if (sel == 1) begin
        invalidate_idle();
      end else begin
        a   = (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
        inv = $urandom_range(0, 9);
        fetch(a, $urandom_range(0, 4), (inv == 0) ? 1 : (inv == 1) ? 2 : 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
